// File: rtl/multi_cycle_controller_pkg.sv
// Shared encodings for the multi-cycle controller: FSM states, opcodes,
// datapath mux selects, ALU operations and immediate formats.
package ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH,
    DECODE,
    MEM_ADR,
    MEM_READ,
    MEM_WB,
    MEM_WRITE,
    EXEC_R,
    EXEC_I,
    ALU_WB,
    BRANCH,
    JALR,
    JAL,
    LUI,
    HALT
  } state_t;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_B    = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_LUI  = 7'b0110111;

  typedef enum logic [2:0] {
    ALU_ADD  = 3'b000,
    ALU_SUB  = 3'b001,
    ALU_AND  = 3'b010,
    ALU_OR   = 3'b011,
    ALU_SLT  = 3'b100,
    ALU_SLTU = 3'b101,
    ALU_XOR  = 3'b110
  } aluop_t;

  typedef enum logic [2:0] {
    EXT_I = 3'b000,
    EXT_S = 3'b001,
    EXT_B = 3'b010,
    EXT_J = 3'b011,
    EXT_U = 3'b100
  } ext_t;

  typedef enum logic [1:0] {
    RES_ALUOUT = 2'b00,
    RES_MEM    = 2'b01,
    RES_ALU    = 2'b10,
    RES_IMMEXT = 2'b11
  } res_sel_t;

  typedef enum logic [1:0] {
    SRCA_PC    = 2'b00,
    SRCA_OLDPC = 2'b01,
    SRCA_RD1   = 2'b10
  } src_a_t;

  typedef enum logic [1:0] {
    SRCB_RD2  = 2'b00,
    SRCB_IMM  = 2'b01,
    SRCB_FOUR = 2'b10
  } src_b_t;

  typedef struct packed {
    logic     pc_write;
    logic     adr_sel;
    logic     mem_we;
    logic     ir_we;
    logic     wereg;
    res_sel_t result_sel;
    src_a_t   alu_src_a;
    src_b_t   alu_src_b;
    aluop_t   aluop;
    ext_t     extend_func;
    logic     instr_done;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE = '{
    pc_write:    1'b0,
    adr_sel:     1'b0,
    mem_we:      1'b0,
    ir_we:       1'b0,
    wereg:       1'b0,
    result_sel:  RES_ALUOUT,
    alu_src_a:   SRCA_PC,
    alu_src_b:   SRCB_RD2,
    aluop:       ALU_ADD,
    extend_func: EXT_I,
    instr_done:  1'b0
  };

endpackage

// File: rtl/multi_cycle_controller_if.sv
// Controller <-> datapath bundle: instruction fields and ALU flags in,
// datapath enables and mux selects out.
interface multi_cycle_controller_if;

  logic [6:0] op;
  logic [2:0] func3;
  logic [6:0] func7;
  logic       zero;
  logic       neg;

  logic       pc_write;
  logic       adr_sel;
  logic       mem_we;
  logic       ir_we;
  logic       wereg;
  logic [1:0] result_sel;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [2:0] aluop;
  logic [2:0] extend_func;
  logic       instr_done;
  logic       illegal;

  modport master (
    input  op, func3, func7, zero, neg,
    output pc_write, adr_sel, mem_we, ir_we, wereg, result_sel,
           alu_src_a, alu_src_b, aluop, extend_func, instr_done, illegal
  );

  modport slave (
    output op, func3, func7, zero, neg,
    input  pc_write, adr_sel, mem_we, ir_we, wereg, result_sel,
           alu_src_a, alu_src_b, aluop, extend_func, instr_done, illegal
  );

endinterface

// File: rtl/multi_cycle_controller_alu_decoder.sv
// Combinational ALU operation decode for R- and I-type arithmetic;
// flags func3 codes the datapath does not implement (shifts).
module alu_decoder
  import ctrl_pkg::*;
(
  input  logic [6:0] op,
  input  logic [2:0] func3,
  input  logic [6:0] func7,
  output aluop_t     aluop,
  output logic       invalid
);

  // Only func7[5] selects sub; the remaining bits carry no meaning here.
  logic func7_unused;
  assign func7_unused = ^{func7[6], func7[4:0]};

  always_comb begin
    aluop   = ALU_ADD;
    invalid = 1'b0;
    unique case (func3)
      3'b000:  aluop = (op == OP_R && func7[5]) ? ALU_SUB : ALU_ADD;
      3'b010:  aluop = ALU_SLT;
      3'b011:  aluop = ALU_SLTU;
      3'b100:  aluop = ALU_XOR;
      3'b110:  aluop = ALU_OR;
      3'b111:  aluop = ALU_AND;
      default: invalid = 1'b1;
    endcase
  end

endmodule

// File: rtl/multi_cycle_controller.sv
// Multi-cycle RV32 subset control FSM: sequences fetch, decode, memory,
// ALU, branch and jump steps and flags unsupported instructions.
module multi_cycle_controller
  import ctrl_pkg::*;
(
  input logic                      clk,
  input logic                      rst,
  multi_cycle_controller_if.master bus
);

  state_t state;
  state_t nxt;
  ctrl_t  outs_q;
  logic   illegal_q;
  aluop_t dec_aluop;
  logic   dec_invalid;
  logic   br_valid;
  logic   br_taken;

  alu_decoder u_alu_decoder (
    .op      (bus.op),
    .func3   (bus.func3),
    .func7   (bus.func7),
    .aluop   (dec_aluop),
    .invalid (dec_invalid)
  );

  always_comb begin
    br_valid = 1'b1;
    br_taken = 1'b0;
    unique case (bus.func3)
      3'b000:  br_taken = bus.zero;
      3'b001:  br_taken = ~bus.zero;
      3'b100:  br_taken = bus.neg;
      3'b101:  br_taken = ~bus.neg;
      default: br_valid = 1'b0;
    endcase
  end

  always_comb begin
    nxt = state;
    unique case (state)
      FETCH:     nxt = DECODE;
      DECODE: begin
        unique case (bus.op)
          OP_LW, OP_SW: nxt = MEM_ADR;
          OP_R:         nxt = EXEC_R;
          OP_I:         nxt = EXEC_I;
          OP_B:         nxt = BRANCH;
          OP_JAL:       nxt = JAL;
          OP_JALR:      nxt = JALR;
          OP_LUI:       nxt = LUI;
          default:      nxt = HALT;
        endcase
      end
      MEM_ADR:   nxt = (bus.op == OP_SW) ? MEM_WRITE : MEM_READ;
      MEM_READ:  nxt = MEM_WB;
      MEM_WB:    nxt = FETCH;
      MEM_WRITE: nxt = FETCH;
      EXEC_R,
      EXEC_I:    nxt = dec_invalid ? HALT : ALU_WB;
      ALU_WB:    nxt = FETCH;
      BRANCH:    nxt = br_valid ? FETCH : HALT;
      JALR:      nxt = JAL;
      JAL:       nxt = ALU_WB;
      LUI:       nxt = FETCH;
      HALT:      nxt = HALT;
      default:   nxt = HALT;
    endcase
  end

  // Outputs of the state being entered, built from the instruction fields
  // that are stable during the cycle before it.
  function automatic ctrl_t outs_for(input state_t st, input logic [6:0] op,
                                     input aluop_t alu);
    ctrl_t c;
    c = CTRL_IDLE;
    unique case (st)
      FETCH: begin
        c.ir_we      = 1'b1;
        c.pc_write   = 1'b1;
        c.alu_src_a  = SRCA_PC;
        c.alu_src_b  = SRCB_FOUR;
        c.result_sel = RES_ALU;
      end
      DECODE: begin
        c.alu_src_a   = SRCA_OLDPC;
        c.alu_src_b   = SRCB_IMM;
        c.extend_func = EXT_B;
      end
      MEM_ADR: begin
        c.alu_src_a   = SRCA_RD1;
        c.alu_src_b   = SRCB_IMM;
        c.extend_func = (op == OP_SW) ? EXT_S : EXT_I;
      end
      MEM_READ: begin
        c.adr_sel    = 1'b1;
        c.result_sel = RES_ALUOUT;
      end
      MEM_WB: begin
        c.result_sel = RES_MEM;
        c.wereg      = 1'b1;
        c.instr_done = 1'b1;
      end
      MEM_WRITE: begin
        c.adr_sel    = 1'b1;
        c.result_sel = RES_ALUOUT;
        c.mem_we     = 1'b1;
        c.instr_done = 1'b1;
      end
      EXEC_R: begin
        c.alu_src_a = SRCA_RD1;
        c.alu_src_b = SRCB_RD2;
        c.aluop     = alu;
      end
      EXEC_I: begin
        c.alu_src_a   = SRCA_RD1;
        c.alu_src_b   = SRCB_IMM;
        c.extend_func = EXT_I;
        c.aluop       = alu;
      end
      ALU_WB: begin
        c.result_sel = RES_ALUOUT;
        c.wereg      = 1'b1;
        c.instr_done = 1'b1;
      end
      BRANCH: begin
        c.alu_src_a  = SRCA_RD1;
        c.alu_src_b  = SRCB_RD2;
        c.aluop      = ALU_SUB;
        c.result_sel = RES_ALUOUT;
        c.instr_done = 1'b1;
      end
      JALR: begin
        c.alu_src_a   = SRCA_RD1;
        c.alu_src_b   = SRCB_IMM;
        c.extend_func = EXT_I;
      end
      JAL: begin
        c.result_sel = RES_ALUOUT;
        c.pc_write   = 1'b1;
        c.alu_src_a  = SRCA_OLDPC;
        c.alu_src_b  = SRCB_FOUR;
      end
      LUI: begin
        c.extend_func = EXT_U;
        c.result_sel  = RES_IMMEXT;
        c.wereg       = 1'b1;
        c.instr_done  = 1'b1;
      end
      default: ;
    endcase
    return c;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= FETCH;
      outs_q    <= outs_for(FETCH, OP_LW, ALU_ADD);
      illegal_q <= 1'b0;
    end else begin
      state     <= nxt;
      outs_q    <= outs_for(nxt, bus.op, dec_aluop);
      illegal_q <= illegal_q | (nxt == HALT);
    end
  end

  // The new IR only becomes visible in DECODE and the ALU flags only in
  // BRANCH, so those two outputs are resolved combinationally in-state.
  assign bus.extend_func = (state == DECODE && bus.op == OP_JAL) ? EXT_J
                                                                 : outs_q.extend_func;
  assign bus.pc_write    = (outs_q.pc_write | (state == BRANCH && br_valid && br_taken))
                           & ~rst;
  assign bus.ir_we       = outs_q.ir_we & ~rst;
  assign bus.mem_we      = outs_q.mem_we & ~rst;
  assign bus.wereg       = outs_q.wereg & ~rst;
  assign bus.instr_done  = outs_q.instr_done & ~rst;
  assign bus.adr_sel     = outs_q.adr_sel;
  assign bus.result_sel  = outs_q.result_sel;
  assign bus.alu_src_a   = outs_q.alu_src_a;
  assign bus.alu_src_b   = outs_q.alu_src_b;
  assign bus.aluop       = outs_q.aluop;
  assign bus.illegal     = illegal_q;

endmodule
